// File: rtl/shifter_pkg.sv
// Shared types for the iterative shifter.
//   shift_op_e : operation codes carried on shift_type (6 and 7 decode to PASS)
//   state_e    : control FSM states
//   decode_op  : maps the raw 3-bit shift_type onto shift_op_e
package shifter_pkg;

  typedef enum logic [2:0] {
    SH_SLL  = 3'd0,
    SH_SRL  = 3'd1,
    SH_SRA  = 3'd2,
    SH_PASS = 3'd3,
    SH_ROL  = 3'd4,
    SH_ROR  = 3'd5
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  function automatic shift_op_e decode_op(input logic [2:0] code);
    shift_op_e op;
    case (code)
      3'd0:    op = SH_SLL;
      3'd1:    op = SH_SRL;
      3'd2:    op = SH_SRA;
      3'd4:    op = SH_ROL;
      3'd5:    op = SH_ROR;
      default: op = SH_PASS;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One iteration of the shifter: applies op to data by k bits (k <= STEP).
//   data   : current operand
//   k      : bits to move this step
//   op     : operation
//   result : data after the step
module shift_step
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 8
) (
  input  logic [WIDTH-1:0]       data,
  input  logic [$clog2(STEP):0]  k,
  input  shift_op_e              op,
  output logic [WIDTH-1:0]       result
);

  always_comb begin
    result = data;
    case (op)
      SH_SLL:  result = data << k;
      SH_SRL:  result = data >> k;
      SH_SRA:  result = $signed(data) >>> k;
      // k == 0 makes the complementary shift WIDTH, which yields zero, so
      // the rotate degenerates cleanly to data.
      SH_ROL:  result = (data << k) | (data >> (WIDTH - k));
      SH_ROR:  result = (data >> k) | (data << (WIDTH - k));
      default: result = data;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter/rotator with valid/ready handshakes on both sides.
// Moves at most STEP bits per clock; result is presented in DONE until taken.
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid / in_ready   : request handshake (ready only in IDLE)
//   val, shamt, shift_type: operand, shift amount, operation code
//   out_valid / out_ready : result handshake (valid only in DONE)
//   shifted_val           : result (data register)
module iter_shifter
  import shifter_pkg::*;
#(
  parameter  int unsigned WIDTH   = 32,
  parameter  int unsigned STEP    = 8,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   val,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [2:0]         shift_type,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   shifted_val
);

  localparam int unsigned KW = $clog2(STEP) + 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q;
  logic [SHAMT_W-1:0] rem_q;
  shift_op_e          op_q;

  logic               accept;
  shift_op_e          in_op;
  logic [KW-1:0]      k;
  logic [SHAMT_W-1:0] rem_next;
  logic [WIDTH-1:0]   step_res;

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign shifted_val = data_q;

  assign accept = in_valid & in_ready;
  assign in_op  = decode_op(shift_type);

  // k = min(rem, STEP); compared at 32 bits because STEP may equal WIDTH
  // and then does not fit in SHAMT_W bits.
  always_comb begin
    if (32'(rem_q) < STEP) k = KW'(rem_q);
    else                   k = KW'(STEP);
    rem_next = rem_q - SHAMT_W'(k);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data   (data_q),
    .k      (k),
    .op     (op_q),
    .result (step_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (shamt == '0 || in_op == SH_PASS) state_d = ST_DONE;
          else                                 state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (rem_next == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      rem_q  <= '0;
      op_q   <= SH_SLL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            data_q <= val;
            rem_q  <= shamt;
            op_q   <= in_op;
          end
        end
        ST_SHIFT: begin
          data_q <= step_res;
          rem_q  <= rem_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
module tb_iter_shifter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned STEP  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  val;
  logic [4:0]        shamt;
  logic [2:0]        shift_type;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  shifted_val;

  int tests = 0;
  int fails = 0;

  iter_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .val         (val),
    .shamt       (shamt),
    .shift_type  (shift_type),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .shifted_val (shifted_val)
  );

  always #5 clk = ~clk;

  // Reference: whole shift done in one go, straight from the operation rules.
  function automatic logic [31:0] ref_shift(input logic [31:0] v, input int s, input int t);
    logic [63:0] dbl;
    dbl = {v, v};
    case (t)
      0: return v << s;
      1: return v >> s;
      2: return $unsigned($signed(v) >>> s);
      4: begin dbl = dbl << s; return dbl[63:32]; end
      5: begin dbl = dbl >> s; return dbl[31:0]; end
      default: return v;
    endcase
  endfunction

  function automatic int ref_lat(input int s, input int t);
    if (t == 3 || t >= 6 || s == 0) return 1;
    return 1 + (s + STEP - 1) / STEP;
  endfunction

  // Drives one request from an IDLE state (called #1 after an edge),
  // reports the cycle out_valid rose and the result, then consumes it
  // after 'stall' extra cycles.
  task automatic do_op(input logic [31:0] v, input int s, input int t, input int stall,
                       output logic [31:0] res, output int lat);
    in_valid = 1'b1; val = v; shamt = 5'(s); shift_type = 3'(t); out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = shifted_val;
    repeat (stall) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    val = '0; shamt = '0; shift_type = '0;
    #1;
    tests++;
    if ({in_ready, out_valid, shifted_val} !== {1'b1, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b vld=%b val=%h want 1 0 0", in_ready, out_valid, shifted_val);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sll;
    in_valid = 1'b1; val = 32'd21; shamt = 5'd2; shift_type = 3'd0; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if ({in_ready, out_valid} !== 2'b00) begin
      fails++; $display("FAIL sll_cycle1: got rdy=%b vld=%b want 0 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    tests++;
    if ({in_ready, out_valid, shifted_val} !== {1'b0, 1'b1, 32'd84}) begin
      fails++; $display("FAIL sll_cycle2: got rdy=%b vld=%b val=%0d want 0 1 84", in_ready, out_valid, shifted_val);
    end
    @(posedge clk); #1;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++; $display("FAIL sll_cycle3: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_directed;
    logic [31:0] res, ev [8];
    int lat;
    int vs [8], ss [8], ts [8], ls [8];
    ev = '{32'hFFFFFFFA, 32'h3FFFFFFA, 32'h00001800, 32'h00000018,
           32'h12345678, 32'h12345678, 32'hCAFEF00D, 32'h00000000};
    vs = '{32'hFFFFFFEB, 32'hFFFFFFEB, 32'h80000001, 32'h80000001,
           32'h12345678, 32'h12345678, 32'hCAFEF00D, 32'h00000000};
    ss = '{2, 2, 20, 4, 17, 17, 0, 0};
    ts = '{2, 1, 5, 4, 3, 7, 0, 0};
    ls = '{2, 2, 4, 2, 1, 1, 1, 1};
    for (int i = 0; i < 7; i++) begin
      do_op(vs[i], ss[i], ts[i], 0, res, lat);
      tests++;
      if (res !== ev[i] || lat != ls[i]) begin
        fails++;
        $display("FAIL directed_%0d: got %h@cycle%0d want %h@cycle%0d", i, res, lat, ev[i], ls[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] v, res, exp;
    int s, t, lat;
    for (int i = 0; i < 60; i++) begin
      v = $urandom;
      s = $urandom_range(0, 31);
      t = $urandom_range(0, 7);
      do_op(v, s, t, $urandom_range(0, 2), res, lat);
      exp = ref_shift(v, s, t);
      tests++;
      if (res !== exp || lat != ref_lat(s, t)) begin
        fails++;
        $display("FAIL random op=%0d v=%h s=%0d: got %h@%0d want %h@%0d", t, v, s, res, lat, exp, ref_lat(s, t));
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] res;
    int lat;
    in_valid = 1'b1; val = 32'd1; shamt = 5'd31; shift_type = 3'd0; out_ready = 1'b0;
    @(posedge clk); #1;
    // second request stays presented throughout
    val = 32'h0000000F; shamt = 5'd4; shift_type = 3'd4;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    tests++;
    if (lat != 5) begin
      fails++; $display("FAIL bp_latency: got cycle %0d want 5", lat);
    end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({out_valid, in_ready, shifted_val} !== {1'b1, 1'b0, 32'h80000000}) begin
        fails++; $display("FAIL bp_hold_%0d: got vld=%b rdy=%b val=%h want 1 0 80000000", i, out_valid, in_ready, shifted_val);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++; $display("FAIL bp_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL bp_second_accept: got rdy=%b want 0", in_ready);
    end
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    tests++;
    if (shifted_val !== 32'h000000F0 || lat != 2) begin
      fails++; $display("FAIL bp_second_result: got %h@%0d want 000000f0@2", shifted_val, lat);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] res;
    int lat;
    in_valid = 1'b1; val = $urandom; shamt = 5'd24; shift_type = 3'd1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    tests++;
    if ({out_valid, in_ready, shifted_val} !== {1'b0, 1'b1, 32'h0}) begin
      fails++; $display("FAIL reset_mid: got vld=%b rdy=%b val=%h want 0 1 0", out_valid, in_ready, shifted_val);
    end
    out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_no_result: got vld=%b want 0", out_valid);
    end
    do_op(32'd3, 9, 0, 0, res, lat);
    tests++;
    if (res !== 32'h600 || lat != 3) begin
      fails++; $display("FAIL reset_recover: got %h@%0d want 00000600@3", res, lat);
    end
  endtask

  initial begin
    test_reset;
    test_sll;
    test_directed;
    test_backpressure;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Parametrised, multi-cycle successor to the ALU's combinational shifter.
- Shifts a WIDTH-bit operand by up to WIDTH-1 positions, moving at most STEP bits per clock, which keeps the critical path short.
- Adds rotate modes and a valid/ready handshake on both input and output.
- Sits beside the ALU in the execute stage; the pipeline stalls while the block is busy.

Parameters:
- WIDTH, 32: operand width; must be a power of 2, at least 8.
- STEP, 8: maximum bits shifted per cycle; must be a power of 2, 1 ≤ STEP ≤ WIDTH.
- SHAMT_W, $clog2(WIDTH): localparam, width of the shift-amount field.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- val  input  WIDTH  operand.
- shamt  input  SHAMT_W  shift amount.
- shift_type  input  3  operation (encoding below).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- shifted_val  output  WIDTH  result.

Behaviour:
- Encoding of shift_type:
  - 0 SLL, 1 SRL, 2 SRA, 3 PASS, 4 ROL, 5 ROR.
  - 6 and 7 behave as PASS.
  - Codes 0-3 match the existing combinational shifter bit-for-bit.
- States: IDLE, SHIFT, DONE.
- in_ready = (state == IDLE). out_valid = (state == DONE). Both are decoded directly from state.
- Reset, asynchronous and active-high:
  - state goes to IDLE; data, remaining-count and op registers clear to 0.
  - During reset: in_ready = 1, out_valid = 0, shifted_val = 0.
  - Reset mid-SHIFT or mid-DONE aborts the operation; no result is produced.
- IDLE:
  - On in_valid & in_ready: capture val, shamt and op; rem = shamt.
  - Next state is DONE if shamt == 0 or op is PASS/6/7; otherwise SHIFT.
- SHIFT, every edge:
  - k = min(rem, STEP); data = op(data, k); rem = rem − k.
  - If the new rem == 0, go to DONE.
  - Number of SHIFT cycles = ceil(shamt / STEP).
- Latency: taking the accept cycle as cycle 0, out_valid is high in cycle 1 + ceil(shamt / STEP). PASS and shamt = 0 give cycle 1.
- DONE:
  - shifted_val = data register.
  - shifted_val and out_valid stay stable while out_ready = 0.
  - On out_ready, go to IDLE; the next request can be accepted in the following cycle.
  - Throughput: one op per 2 + ceil(shamt / STEP) cycles.
- Inputs are ignored when in_ready = 0; no new request is accepted in SHIFT or DONE.
- Arithmetic rules:
  - SLL and SRL zero-fill.
  - SRA fills with the captured MSB; each step preserves the sign, so the result equals a single $signed >>> by shamt.
  - ROL and ROR wrap bits modulo WIDTH.
  - shamt is inherently less than WIDTH; there is no overflow case.
- shifted_val in non-DONE states is the data register contents, and is don't-care for consumers.

Decomposition:
- shifter_pkg holds:
  - typedef enum logic [2:0] shift_op_e {SH_SLL, SH_SRL, SH_SRA, SH_PASS, SH_ROL, SH_ROR}.
  - typedef enum for FSM state.
- One sub-module, shift_step: combinational, parametrised by WIDTH and STEP; applies op to data by k ≤ STEP bits.
- iter_shifter holds the FSM, registers and handshake.
- The existing shifter remains for single-cycle use.

Test Plan (WIDTH=32, STEP=8):
- SLL: val=21, shamt=2, out_ready=1 → shifted_val=84. in_ready low in cycles 1-2. out_valid high in cycle 2 only.
- SRA and SRL: val=0xFFFFFFEB, shamt=2 → SRA gives 0xFFFFFFFA; SRL gives 0x3FFFFFFA. Each has out_valid in cycle 2.
- ROR: val=0x80000001, shamt=20 → three SHIFT steps (8, 8, 4); out_valid in cycle 4; shifted_val=0x00001800. ROL: val=0x80000001, shamt=4 → 0x00000018.
- PASS, zero shift and invalid op:
  - shift_type=3, val=0x12345678, shamt=17 → 0x12345678 in cycle 1.
  - shift_type=7 → same result.
  - SLL with shamt=0 → result equals val, in cycle 1.
- Backpressure: SLL val=1, shamt=31; hold out_ready=0 for 5 cycles while in_valid stays high with a new request.
  - shifted_val holds 0x80000000 and out_valid stays high throughout.
  - The second request is accepted only in the cycle after out_ready is raised.
- Reset mid-operation: assert reset in the 2nd SHIFT cycle of SRL shamt=24.
  - out_valid=0 and in_ready=1 immediately, before the next clock edge.
  - After release, a new SLL val=3, shamt=9 returns 0x600 in cycle 3.
